// File: rtl/pipelined_div_recombiner.sv
// Rebuilds dividend = quotient*divisor + remainder through a DIVISORLEN-stage shift-add pipeline
// and flags results that no legal divider could produce.
// Latency DIVISORLEN clocks from input sample to output; no backpressure, one result per clock.
// Ports: clock/reset_n (async active-low); in_valid + quotient/divisor/remainder operands;
//        out_valid + dividend/ovf/rem_err/div_zero result; err_count saturating error tally.
module pipelined_div_recombiner #(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  input  logic [DIVIDENDLEN-1:0]            quotient,
  input  logic [DIVISORLEN-1:0]             divisor,
  input  logic [DIVISORLEN-1:0]             remainder,
  output logic                              out_valid,
  output logic [DIVIDENDLEN+DIVISORLEN-1:0] dividend,
  output logic                              ovf,
  output logic                              rem_err,
  output logic                              div_zero,
  output logic [15:0]                       err_count
);

  localparam int W = DIVIDENDLEN + DIVISORLEN;
  localparam int L = DIVISORLEN;

  // reg[0] holds freshly sampled operands; reg[L] feeds the outputs.
  logic                   st_vld      [0:L];
  logic [W-1:0]           st_acc      [0:L];
  logic [DIVIDENDLEN-1:0] st_q        [0:L];
  logic [DIVISORLEN-1:0]  st_d        [0:L];
  logic                   st_rem_err  [0:L];
  logic                   st_div_zero [0:L];

  // Partial product added between reg[k] and reg[k+1]: divisor bit k selects q << k.
  logic [W-1:0]           st_add      [0:L-1];

  logic [15:0]            err_cnt;
  logic                   any_err;

  always_comb begin
    for (int k = 0; k < L; k++) begin
      st_add[k] = '0;
      if (st_d[k][k]) st_add[k] = W'(st_q[k]) << k;
    end
  end

  // Result fields are gated so nothing leaks out on a bubble.
  assign out_valid = st_vld[L];
  assign dividend  = st_vld[L] ? st_acc[L] : '0;
  assign ovf       = st_vld[L] & (|st_acc[L][W-1:DIVIDENDLEN]);
  assign rem_err   = st_vld[L] & st_rem_err[L];
  assign div_zero  = st_vld[L] & st_div_zero[L];
  assign any_err   = out_valid & (ovf | rem_err | div_zero);
  assign err_count = err_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= L; k++) begin
        st_vld[k]      <= 1'b0;
        st_acc[k]      <= '0;
        st_q[k]        <= '0;
        st_d[k]        <= '0;
        st_rem_err[k]  <= 1'b0;
        st_div_zero[k] <= 1'b0;
      end
      err_cnt <= '0;
    end else begin
      // Data loads every cycle; only the valid bit distinguishes a bubble.
      st_vld[0]      <= in_valid;
      st_acc[0]      <= W'(remainder);
      st_q[0]        <= quotient;
      st_d[0]        <= divisor;
      st_rem_err[0]  <= (remainder >= divisor); // also covers divisor == 0
      st_div_zero[0] <= (divisor == '0);

      for (int k = 0; k < L; k++) begin
        st_vld[k+1]      <= st_vld[k];
        st_acc[k+1]      <= st_acc[k] + st_add[k];
        st_q[k+1]        <= st_q[k];
        st_d[k+1]        <= st_d[k];
        st_rem_err[k+1]  <= st_rem_err[k];
        st_div_zero[k+1] <= st_div_zero[k];
      end

      // Saturate at all-ones rather than wrapping.
      if (any_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipelined_div_recombiner.sv
module tb_pipelined_div_recombiner;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [7:0]  remainder;
  logic        out_valid;
  logic [23:0] dividend;
  logic        ovf;
  logic        rem_err;
  logic        div_zero;
  logic [15:0] err_count;

  int pass_cnt  = 0;
  int check_cnt = 0;

  pipelined_div_recombiner #(.DIVIDENDLEN(16), .DIVISORLEN(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .out_valid (out_valid),
    .dividend  (dividend),
    .ovf       (ovf),
    .rem_err   (rem_err),
    .div_zero  (div_zero),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle 1ns past the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] q, input logic [7:0] d, input logic [7:0] r);
    in_valid  = v;
    quotient  = q;
    divisor   = d;
    remainder = r;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (dividend !== 24'h0) $display("FAIL reset_dividend got=%h exp=000000", dividend);
    else pass_cnt++;
    check_cnt++;
    if ({ovf, rem_err, div_zero} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {ovf, rem_err, div_zero});
    else pass_cnt++;
    check_cnt++;
    if (err_count !== 16'h0) $display("FAIL reset_err_count got=%h exp=0000", err_count);
    else pass_cnt++;
  endtask

  // One operation: checks not-yet-valid after 7 clocks, result after 8, err_count one clock later.
  task automatic test_single(input string name, input logic [15:0] q, input logic [7:0] d,
                             input logic [7:0] r, input logic [23:0] exp_div, input logic [2:0] exp_flags,
                             input logic [15:0] exp_cnt);
    drive(1'b1, q, d, r);
    tick();
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < 7; i++) tick();
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s_early got=%b exp=0", name, out_valid);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL %s_valid got=%b exp=1", name, out_valid);
    else pass_cnt++;
    check_cnt++;
    if (dividend !== exp_div) $display("FAIL %s_dividend got=%h exp=%h", name, dividend, exp_div);
    else pass_cnt++;
    check_cnt++;
    if ({ovf, rem_err, div_zero} !== exp_flags)
      $display("FAIL %s_flags got=%b exp=%b (ovf,rem_err,div_zero)", name, {ovf, rem_err, div_zero}, exp_flags);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (err_count !== exp_cnt) $display("FAIL %s_err_count got=%h exp=%h", name, err_count, exp_cnt);
    else pass_cnt++;
    idle(2);
  endtask

  // Eight back-to-back inputs q=i,d=3,r=1, a bubble, then q=8; invalid-cycle operands carry
  // divisor 0 to prove they never raise flags or count.
  task automatic test_back_to_back();
    logic        exp_v   [0:9];
    logic [23:0] exp_d   [0:9];
    int          seen = 0;
    for (int j = 0; j < 10; j++) begin
      exp_v[j] = (j != 8);
      exp_d[j] = (j < 8) ? 24'(3 * j + 1) : ((j == 9) ? 24'd25 : 24'd0);
    end
    for (int c = 0; c < 20; c++) begin
      if (c < 8)       drive(1'b1, 16'(c), 8'h03, 8'h01);
      else if (c == 9) drive(1'b1, 16'd8, 8'h03, 8'h01);
      else             drive(1'b0, 16'hFFFF, 8'h00, 8'hFF);
      tick();
      if (c >= 8) begin
        logic        ev;
        logic [23:0] ed;
        ev = (c - 8 < 10) ? exp_v[c-8] : 1'b0;
        ed = (c - 8 < 10) ? exp_d[c-8] : 24'd0;
        check_cnt++;
        if (out_valid !== ev || dividend !== ed || {ovf, rem_err, div_zero} !== 3'b000)
          $display("FAIL b2b_out_%0d got=%b/%h/%b exp=%b/%h/000", c - 8, out_valid, dividend,
                   {ovf, rem_err, div_zero}, ev, ed);
        else pass_cnt++;
      end
      if (out_valid) seen++;
    end
    check_cnt++;
    if (seen != 9) $display("FAIL b2b_count got=%0d exp=9", seen);
    else pass_cnt++;
    check_cnt++;
    if (err_count !== 16'd2) $display("FAIL b2b_err_count got=%h exp=0002", err_count);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_reset_mid();
    // Three in flight, reset two cycles later.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(i + 1), 8'h01, 8'h00);
      tick();
    end
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || err_count !== 16'h0)
      $display("FAIL rst_mid_early got=%b/%h exp=0/0000", out_valid, err_count);
    else pass_cnt++;
    tick();
    #2;
    reset_n = 1'b1;
    // Now fill the pipe until a result is at the outputs and reset asynchronously.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'h0010, 8'h00, 8'h01);
      tick();
    end
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL rst_mid_prefill got=%b exp=1", out_valid);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || dividend !== 24'h0 || div_zero !== 1'b0 || err_count !== 16'h0)
      $display("FAIL rst_mid_async got=%b/%h/%b/%h exp=0/000000/0/0000", out_valid, dividend,
               div_zero, err_count);
    else pass_cnt++;
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    tick();
    #2;
    reset_n = 1'b1;
    begin
      int stale = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid !== 1'b0 || err_count !== 16'h0) stale++;
      end
      check_cnt++;
      if (stale != 0) $display("FAIL rst_mid_stale got=%0d exp=0", stale);
      else pass_cnt++;
    end
    // First post-release input returns after full latency.
    test_single("rst_mid_first", 16'h0100, 8'h02, 8'h01, 24'h000201, 3'b000, 16'h0000);
  endtask

  task automatic test_saturate();
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    #1;
    check_cnt++;
    if (err_count !== 16'hFFFE) $display("FAIL sat_preload got=%h exp=fffe", err_count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0001, 8'h00, 8'h00);
      tick();
    end
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    // Results emerge at ticks 8..10 after the first; counts land one tick later.
    for (int i = 0; i < 6; i++) tick();
    check_cnt++;
    if (err_count !== 16'hFFFE) $display("FAIL sat_before got=%h exp=fffe", err_count);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (err_count !== 16'hFFFF) $display("FAIL sat_reach got=%h exp=ffff", err_count);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (err_count !== 16'hFFFF || out_valid !== 1'b1)
      $display("FAIL sat_hold1 got=%h/%b exp=ffff/1", err_count, out_valid);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (err_count !== 16'hFFFF) $display("FAIL sat_hold2 got=%h exp=ffff", err_count);
    else pass_cnt++;
    idle(3);
    check_cnt++;
    if (err_count !== 16'hFFFF) $display("FAIL sat_hold3 got=%h exp=ffff", err_count);
    else pass_cnt++;
  endtask

  initial begin
    drive(1'b0, 16'h0, 8'h0, 8'h0);
    reset_n = 1'b0;
    test_reset();
    test_single("basic", 16'h1234, 8'h05, 8'h03, 24'h005B07, 3'b000, 16'h0000);
    test_single("ovf",   16'hFFFF, 8'hFF, 8'hFE, 24'hFEFFFF, 3'b100, 16'h0001);
    test_single("dz",    16'h00AA, 8'h00, 8'h05, 24'h000005, 3'b011, 16'h0002);
    test_single("rem_eq", 16'h0002, 8'h10, 8'h10, 24'h000030, 3'b010, 16'h0003);
    test_single("max_ok", 16'hFF00, 8'h01, 8'h00, 24'h00FF00, 3'b000, 16'h0003);
    force dut.err_cnt = 16'h0002;
    #1;
    release dut.err_cnt;
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
